// File: rtl/alu_imm_exec.sv
// RV32I execute slice: immediate decode, operand-B select, integer ALU and pipeline output register.
// Define ALU_FLAGS_EN to add carry/overflow/negative outputs and their registered copies.
module alu_imm_exec #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [3:0]      alu_ctrl,
  input  logic            alu_src,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [24:0]     src,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm_signed,
  output logic [XLEN-1:0] results,
  output logic            zero,
  output logic [XLEN-1:0] results_q,
  output logic            zero_q
`ifdef ALU_FLAGS_EN
  ,
  output logic            carry,
  output logic            overflow,
  output logic            negative,
  output logic            carry_q,
  output logic            overflow_q,
  output logic            negative_q
`endif
);

  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned IMM_I_W  = 12;
  localparam int unsigned IMM_B_W  = 13;
  localparam int unsigned IMM_U_LO = 12;
  localparam int unsigned IMM_J_W  = 21;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;

  logic [XLEN-1:0]    op_b;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    add_res;
  logic [XLEN-1:0]    sub_res;
  logic               sign_bit;

  assign sign_bit = src[24];

  // Immediate reassembly from the scattered RV32I encoding fields; sign always from instr[31].
  always_comb begin
    imm_signed = '0;
    unique case (imm_src)
      IMM_I: imm_signed = {{(XLEN-IMM_I_W){sign_bit}}, src[24:13]};
      IMM_S: imm_signed = {{(XLEN-IMM_I_W){sign_bit}}, src[24:18], src[4:0]};
      IMM_B: imm_signed = {{(XLEN-IMM_B_W){sign_bit}}, src[24], src[0], src[23:18],
                           src[4:1], 1'b0};
      IMM_U: imm_signed = {src[24:5], {IMM_U_LO{1'b0}}};
      IMM_J: imm_signed = {{(XLEN-IMM_J_W){sign_bit}}, src[24], src[12:5], src[13],
                           src[23:14], 1'b0};
      default: imm_signed = '0;
    endcase
  end

  assign op_b    = alu_src ? imm_signed : src2;
  assign shamt   = op_b[SHAMT_W-1:0];
  assign add_res = src1 + op_b;
  assign sub_res = src1 - op_b;

  always_comb begin
    results = '0;
    unique case (alu_ctrl)
      OP_ADD:   results = add_res;
      OP_SUB:   results = sub_res;
      OP_AND:   results = src1 & op_b;
      OP_OR:    results = src1 | op_b;
      OP_XOR:   results = src1 ^ op_b;
      OP_SLL:   results = src1 << shamt;
      OP_SRL:   results = src1 >> shamt;
      OP_SRA:   results = XLEN'($signed(src1) >>> shamt);
      OP_SLT:   results = XLEN'($signed(src1) < $signed(op_b));
      OP_SLTU:  results = XLEN'(src1 < op_b);
      OP_PASSB: results = op_b;
      default:  results = '0;
    endcase
  end

  assign zero = (results == '0);

`ifdef ALU_FLAGS_EN
  logic [XLEN:0] add_ext;
  logic [XLEN:0] sub_ext;

  // Subtract as A + ~B + 1 so the top bit is directly the not-borrow carry.
  assign add_ext = {1'b0, src1} + {1'b0, op_b};
  assign sub_ext = {1'b0, src1} + {1'b0, ~op_b} + (XLEN+1)'(1);

  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (alu_ctrl)
      OP_ADD: begin
        carry    = add_ext[XLEN];
        overflow = (src1[XLEN-1] == op_b[XLEN-1]) && (add_res[XLEN-1] != src1[XLEN-1]);
      end
      OP_SUB: begin
        carry    = sub_ext[XLEN];
        overflow = (src1[XLEN-1] != op_b[XLEN-1]) && (sub_res[XLEN-1] != src1[XLEN-1]);
      end
      default: begin
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

  assign negative = results[XLEN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else if (en) begin
      carry_q    <= carry;
      overflow_q <= overflow;
      negative_q <= negative;
    end
  end
`endif

  // Pipeline register toward address generation / branch compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      results_q <= '0;
      zero_q    <= 1'b1;
    end else if (en) begin
      results_q <= results;
      zero_q    <= zero;
    end
  end

endmodule

// File: tb/tb_alu_imm_exec.sv
// Self-checking bench for alu_imm_exec: directed cases plus randomized traffic against an arithmetic model.
module tb_alu_imm_exec;

  localparam longint TWO31 = 64'sh8000_0000;
  localparam longint TWO32 = 64'sh1_0000_0000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  alu_ctrl;
  logic        alu_src;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [24:0] src;
  logic [2:0]  imm_src;
  logic [31:0] imm_signed;
  logic [31:0] results;
  logic        zero;
  logic [31:0] results_q;
  logic        zero_q;
`ifdef ALU_FLAGS_EN
  logic carry, overflow, negative, carry_q, overflow_q, negative_q;
  logic exp_c_q, exp_v_q, exp_n_q;
`endif

  int n_total;
  int n_bad;
  logic [31:0] exp_q;
  logic        exp_zq;

  alu_imm_exec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .alu_ctrl   (alu_ctrl),
    .alu_src    (alu_src),
    .src1       (src1),
    .src2       (src2),
    .src        (src),
    .imm_src    (imm_src),
    .imm_signed (imm_signed),
    .results    (results),
    .zero       (zero),
    .results_q  (results_q),
    .zero_q     (zero_q)
`ifdef ALU_FLAGS_EN
    ,
    .carry      (carry),
    .overflow   (overflow),
    .negative   (negative),
    .carry_q    (carry_q),
    .overflow_q (overflow_q),
    .negative_q (negative_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sext(input longint v, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  function automatic logic [31:0] to_u32(input longint v);
    longint m;
    m = v % TWO32;
    if (m < 0) m += TWO32;
    return 32'(m);
  endfunction

  // Immediate value from the field-placement rules, expressed as integer arithmetic.
  function automatic logic [31:0] model_imm(input logic [24:0] s, input logic [2:0] t);
    longint x;
    longint v;
    x = longint'(s);
    case (t)
      3'd0: v = sext(x / 8192, 12);
      3'd1: v = sext(((x / 262144) % 128) * 32 + (x % 32), 12);
      3'd2: v = sext(((x / 16777216) % 2) * 4096 + (x % 2) * 2048
                     + ((x / 262144) % 64) * 32 + ((x / 2) % 16) * 2, 13);
      3'd3: v = ((x / 32) % 1048576) * 4096;
      3'd4: v = sext(((x / 16777216) % 2) * 1048576 + ((x / 32) % 256) * 4096
                     + ((x / 8192) % 2) * 2048 + ((x / 16384) % 1024) * 2, 21);
      default: v = 0;
    endcase
    return to_u32(v);
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint ua, ub, sa, sb, d, r;
    int sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= TWO31) ? ua - TWO32 : ua;
    sb = (ub >= TWO31) ? ub - TWO32 : ub;
    sh = int'(ub % 32);
    d  = longint'(1) << sh;
    case (op)
      4'd0:  r = ua + ub;
      4'd1:  r = ua - ub;
      4'd2:  r = longint'(a & b);
      4'd3:  r = longint'(a | b);
      4'd4:  r = longint'(a ^ b);
      4'd5:  r = ua * d;
      4'd6:  r = ua / d;
      4'd7:  r = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
      4'd8:  r = (sa < sb) ? 1 : 0;
      4'd9:  r = (ua < ub) ? 1 : 0;
      4'd10: r = ub;
      default: r = 0;
    endcase
    return to_u32(r);
  endfunction

  // Drive one operation at the falling edge, check combinational outputs, then the register after the rising edge.
  task automatic apply(input logic e, input logic [3:0] op, input logic asel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [24:0] s, input logic [2:0] it);
    logic [31:0] m_imm, m_b, m_res;
    @(negedge clk);
    en = e; alu_ctrl = op; alu_src = asel; src1 = a; src2 = b; src = s; imm_src = it;
    #1;
    m_imm = model_imm(s, it);
    m_b   = asel ? m_imm : b;
    m_res = model_alu(op, a, m_b);
    check_val("imm_signed", imm_signed, m_imm);
    check_val("results", results, m_res);
    check_val("zero", 32'(zero), 32'(m_res == 32'd0));
`ifdef ALU_FLAGS_EN
    begin
      logic ec, ev;
      longint ua, ub, sa, sb, sr;
      ua = longint'(a); ub = longint'(m_b);
      sa = (ua >= TWO31) ? ua - TWO32 : ua;
      sb = (ub >= TWO31) ? ub - TWO32 : ub;
      ec = 1'b0; ev = 1'b0;
      if (op == 4'd0) begin
        ec = (ua + ub) >= TWO32; sr = sa + sb; ev = (sr >= TWO31) || (sr < -TWO31);
      end else if (op == 4'd1) begin
        ec = ua >= ub; sr = sa - sb; ev = (sr >= TWO31) || (sr < -TWO31);
      end
      check_val("carry", 32'(carry), 32'(ec));
      check_val("overflow", 32'(overflow), 32'(ev));
      check_val("negative", 32'(negative), 32'(m_res >= 32'h8000_0000));
      if (e) begin exp_c_q = ec; exp_v_q = ev; exp_n_q = m_res[31]; end
    end
`endif
    if (e) begin
      exp_q  = m_res;
      exp_zq = (m_res == 32'd0);
    end
    @(posedge clk);
    #1;
    check_val("results_q", results_q, exp_q);
    check_val("zero_q", 32'(zero_q), 32'(exp_zq));
`ifdef ALU_FLAGS_EN
    check_val("carry_q", 32'(carry_q), 32'(exp_c_q));
    check_val("overflow_q", 32'(overflow_q), 32'(exp_v_q));
    check_val("negative_q", 32'(negative_q), 32'(exp_n_q));
`endif
  endtask

  // Reset pulse between clock edges with enable low, so the next edge must not disturb the reset value.
  task automatic reset_pulse();
    logic [31:0] comb_before;
    @(negedge clk);
    en = 1'b0;
    #1;
    comb_before = model_alu(alu_ctrl, src1, alu_src ? model_imm(src, imm_src) : src2);
    rst_n = 1'b0;
    #1;
    exp_q = 32'd0; exp_zq = 1'b1;
`ifdef ALU_FLAGS_EN
    exp_c_q = 1'b0; exp_v_q = 1'b0; exp_n_q = 1'b0;
`endif
    check_val("async_rst_q", results_q, 32'd0);
    check_val("async_rst_zq", 32'(zero_q), 32'd1);
    check_val("rst_comb_results", results, comb_before);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_q", results_q, 32'd0);
    check_val("post_rst_zq", 32'(zero_q), 32'd1);
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    exp_q = 32'd0; exp_zq = 1'b1;
`ifdef ALU_FLAGS_EN
    exp_c_q = 1'b0; exp_v_q = 1'b0; exp_n_q = 1'b0;
`endif
    rst_n = 1'b0; en = 1'b0; alu_ctrl = 4'b1111; alu_src = 1'b0;
    src1 = '0; src2 = '0; src = '0; imm_src = 3'b111;
    #12;
    check_val("idle_results", results, 32'd0);
    check_val("idle_zero", 32'(zero), 32'd1);
    check_val("idle_results_q", results_q, 32'd0);
    check_val("idle_zero_q", 32'(zero_q), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    apply(1'b1, 4'd0, 1'b1, 32'h1000, 32'h0, 25'h0FFE000, 3'd0);
    check_val("i_pos_imm", imm_signed, 32'h0000_07FF);
    check_val("i_pos_q", results_q, 32'h0000_17FF);
    apply(1'b1, 4'd0, 1'b1, 32'h2000, 32'h0, 25'h1F80000, 3'd0);
    check_val("i_neg_imm", imm_signed, 32'hFFFF_FFC0);
    check_val("i_neg_res", results, 32'h0000_1FC0);
    apply(1'b1, 4'd0, 1'b1, 32'h3000, 32'h0, 25'h0000005, 3'd1);
    check_val("s_res", results, 32'h0000_3005);
    apply(1'b1, 4'd0, 1'b1, 32'h3000, 32'h0, 25'h1FC001F, 3'd1);
    check_val("s_neg_imm", imm_signed, 32'hFFFF_FFFF);
    apply(1'b1, 4'd0, 1'b0, 32'h5000, 32'h0FFF, 25'h0, 3'd0);
    check_val("reg_add", results, 32'h0000_5FFF);
    apply(1'b1, 4'd1, 1'b0, 32'h1234_5678, 32'h1234_5678, 25'h0, 3'd0);
    check_val("sub_zero", 32'(zero), 32'd1);
    apply(1'b1, 4'd7, 1'b0, 32'h8000_0000, 32'd4, 25'h0, 3'd0);
    check_val("sra", results, 32'hF800_0000);
    apply(1'b1, 4'd8, 1'b0, 32'hFFFF_FFFF, 32'd1, 25'h0, 3'd0);
    check_val("slt", results, 32'd1);
    apply(1'b1, 4'd9, 1'b0, 32'hFFFF_FFFF, 32'd1, 25'h0, 3'd0);
    check_val("sltu", results, 32'd0);
    apply(1'b1, 4'd10, 1'b1, 32'h0, 32'h0, 25'h0001220, 3'd3);
    check_val("lui_passb", results, 32'h0009_1000);
    apply(1'b1, 4'd12, 1'b0, 32'hDEAD_BEEF, 32'h1, 25'h0, 3'd0);
    check_val("invalid_op", results, 32'd0);
    apply(1'b1, 4'd4, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 25'h0, 3'd0);
    apply(1'b0, 4'd0, 1'b0, 32'h1111_1111, 32'h2222_2222, 25'h0, 3'd0);
    check_val("hold_en0", results_q, 32'hA5A5_5A5A);
    apply(1'b0, 4'd3, 1'b1, 32'h0F0F_0F0F, 32'h0, 25'h1ABCDEF, 3'd4);
    reset_pulse();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      apply($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            a, b, 25'($urandom), 3'($urandom_range(0, 7)));
      if (i % 97 == 50) reset_pulse();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
